adder_cla_pipe: RTL and testbench

//   Parametrised, pipelined carry-lookahead add/subtract unit for the ALU datapath.

---
 rtl/adder_cla_pipe.sv | 142 ++++++++++++++
 tb/tb_adder_cla_pipe.sv | 130 +++++++++++++
 2 files changed

// File: rtl/adder_cla_pipe.sv
// Pipelined carry-lookahead add/subtract: one GROUP_W-bit CLA group per stage, carries registered between stages.
// Optional saturation of the final result when ADDER_CLA_PIPE_SAT_EN is defined. Requires WIDTH/GROUP_W >= 2.
module adder_cla_pipe #(
    parameter int WIDTH   = 16,
    parameter int GROUP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovfl,
    output logic             zero,
    output logic             neg
);

    localparam int NSTG = WIDTH / GROUP_W;

    // Returns {carries c[GROUP_W:1], sum}; every carry is a flat lookahead term of g/p/ci.
    function automatic logic [2*GROUP_W-1:0] cla_group(
        input logic [GROUP_W-1:0] x,
        input logic [GROUP_W-1:0] y,
        input logic               ci
    );
        logic [GROUP_W-1:0] g;
        logic [GROUP_W-1:0] p;
        logic [GROUP_W-1:0] sum;
        logic [GROUP_W:0]   c;
        logic               pp;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < GROUP_W; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & ci);
        end
        sum = p ^ c[GROUP_W-1:0];
        return {c[GROUP_W:1], sum};
    endfunction

    logic                   adv;
    logic [WIDTH-1:0]       a_in [NSTG];
    logic [WIDTH-1:0]       b_in [NSTG];
    logic [WIDTH-1:0]       s_in [NSTG];
    logic [WIDTH-1:0]       s_nx [NSTG];
    logic                   c_in [NSTG];
    logic                   c_nx [NSTG];
    logic [2*GROUP_W-1:0]   grp  [NSTG];

    logic [WIDTH-1:0]       a_q  [NSTG-1];
    logic [WIDTH-1:0]       b_q  [NSTG-1];
    logic [WIDTH-1:0]       s_q  [NSTG-1];
    logic                   c_q  [NSTG-1];
    logic                   v_q  [NSTG-1];

    logic [WIDTH-1:0]       s_f;
    logic                   ovfl_f;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        localparam logic [WIDTH-1:0] GMASK =
            {{(WIDTH-GROUP_W){1'b0}}, {GROUP_W{1'b1}}} << (k*GROUP_W);
        if (k == 0) begin : g_first
            assign a_in[k] = a;
            assign b_in[k] = sub ? ~b : b;
            assign s_in[k] = '0;
            assign c_in[k] = sub;
        end else begin : g_next
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign s_in[k] = s_q[k-1];
            assign c_in[k] = c_q[k-1];
        end
        assign grp[k]  = cla_group(a_in[k][k*GROUP_W +: GROUP_W],
                                   b_in[k][k*GROUP_W +: GROUP_W], c_in[k]);
        assign s_nx[k] = (s_in[k] & ~GMASK)
                       | (WIDTH'(grp[k][GROUP_W-1:0]) << (k*GROUP_W));
        assign c_nx[k] = grp[k][2*GROUP_W-1];
    end

    // Overflow implies both operand MSBs agree, so a's MSB alone picks the saturation rail.
    always_comb begin
        ovfl_f = c_nx[NSTG-1] ^ grp[NSTG-1][2*GROUP_W-2];
`ifdef ADDER_CLA_PIPE_SAT_EN
        if (ovfl_f)
            s_f = a_in[NSTG-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
        else
            s_f = s_nx[NSTG-1];
`else
        s_f = s_nx[NSTG-1];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTG-1; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            ovfl      <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
        end else if (adv) begin
            v_q[0] <= in_valid;
            for (int k = 1; k < NSTG-1; k++) v_q[k] <= v_q[k-1];
            for (int k = 0; k < NSTG-1; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_nx[k];
                c_q[k] <= c_nx[k];
            end
            out_valid <= v_q[NSTG-2];
            s         <= s_f;
            cout      <= c_nx[NSTG-1];
            ovfl      <= ovfl_f;
            zero      <= (s_f == '0);
            neg       <= s_f[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_adder_cla_pipe.sv
// Directed bench for adder_cla_pipe (WIDTH=16, GROUP_W=4, latency 4).
// Expected results follow ADDER_CLA_PIPE_SAT_EN when it is defined for the build.
module tb_adder_cla_pipe;
    localparam int W = 16;
`ifdef ADDER_CLA_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, sub, out_valid, out_ready;
    logic         cout, ovfl, zero, neg;
    logic [W-1:0] a, b, s;
    int           total  = 0;
    int           passed = 0;
    int           failed = 0;

    always #5 clk = ~clk;

    adder_cla_pipe #(.WIDTH(W), .GROUP_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovfl(ovfl), .zero(zero), .neg(neg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op into an empty pipe and checks latency plus the packed {s,cout,ovfl,zero,neg}.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sv, input logic [W-1:0] es, input logic ec,
                          input logic eo, input logic ez, input logic en);
        a = av; b = bv; sub = sv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_flags"}, 32'({s, cout, ovfl, zero, neg}), 32'({es, ec, eo, ez, en}));
        tick();
        chk({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int   nxt;
        int   rcv;
        int   cyc;
        logic acc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_fields", 32'({s, cout, ovfl, zero, neg}), 32'd0);

        run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0,
               SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 1'b0, SAT ? 1'b0 : 1'b1);
        run_op("eq_sub", 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("ovf_sub", 16'h8000, 16'h0001, 1'b1,
               SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1, 1'b0, SAT ? 1'b1 : 1'b0);
        run_op("wrap_add", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("plain_add", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("borrow_sub", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("neg_ovf", 16'h8000, 16'h8000, 1'b0,
               SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1, SAT ? 1'b0 : 1'b1, SAT ? 1'b1 : 1'b0);

        // Eight back-to-back ops with downstream stalled on cycles 5..8.
        nxt = 0; rcv = 0; cyc = 0;
        while (rcv < 8 && cyc < 40) begin
            cyc++;
            out_ready = !(cyc >= 5 && cyc <= 8);
            in_valid  = (nxt < 8);
            a = W'(nxt); b = 16'h0100; sub = 1'b0;
            #1;
            chk("stream_in_ready", 32'(in_ready), (cyc >= 5 && cyc <= 8) ? 32'd0 : 32'd1);
            if (cyc >= 5 && cyc <= 8) chk("stall_valid", 32'(out_valid), 32'd1);
            if (out_valid) begin
                chk("stream_s", 32'(s), 32'(16'h0100 + W'(rcv)));
                if (out_ready) rcv++;
            end
            acc = in_valid & in_ready;
            tick();
            if (acc) nxt++;
        end
        chk("stream_count", 32'(rcv), 32'd8);
        chk("stream_cycles", 32'(cyc), 32'd16);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) begin
            tick();
            chk("stream_no_dup", 32'(out_valid), 32'd0);
        end

        // Reset with three ops in flight: none may emerge afterwards.
        for (int i = 0; i < 3; i++) begin
            a = W'(16'h0010 + i); b = 16'h0000; sub = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_s", 32'(s), 32'd0);
        repeat (6) begin
            tick();
            chk("flush_discard", 32'(out_valid), 32'd0);
        end
        run_op("post_rst", 16'h1234, 16'h0111, 1'b0, 16'h1345, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
